uart_rx_brg: RTL and testbench
==============================

Name: uart_rx_brg

Overview:
8N1 UART receiver, the receive-side counterpart of the team's baud-rate generator, using the same 2-bit baud select and rate ratios. It builds an internal 16x oversample tick from a base divider. It samples and synchronises the serial line, recovers bytes LSB-first, and presents them on a single-entry valid/ready holding register. Sits between the serial input pad and the user-side byte consumer.

Parameters:
DIV_BASE, 68, clk cycles per 16x tick at 115200 bps (125 MHz system clock); must be >= 2
SYNC_STAGES, 2, flops in the rxd synchroniser; must be >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
sel  input  2  baud select: 00=115200, 01=38400, 10=19200, 11=9600
rxd  input  1  serial line, idle high, asynchronous to clk
data_out  output  8  received byte; valid while data_valid=1
data_valid  output  1  holding register full
data_ready  input  1  consumer accepts byte when data_valid&&data_ready
frame_err  output  1  1-cycle pulse: stop bit sampled 0
overrun  output  1  1-cycle pulse: byte completed while holding register still full
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): FSM=IDLE, synchroniser flops=1, all counters=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
- Tick generator:
  - Multiplier M = 1/3/6/12 for sel 00/01/10/11.
  - Prescaler counts 0..DIV_BASE-1; on wrap, multiplier counter counts 0..M-1; its wrap is a 1-cycle tick.
  - Tick period = DIV_BASE*M clks; bit period = 16 ticks.
  - Both counters held at 0 in IDLE and start counting on the cycle after start detection.
  - sel is latched into M at start detection; sel changes mid-frame are ignored.
- Sampling:
  - Within each bit, ticks are indexed 0..15.
  - The line is sampled at ticks 7, 8 and 9; the bit value is the majority of the three.
  - The decision is made at tick 9.
- FSM:
  - IDLE: synchronised rxd==0 -> START.
  - START: at decision, bit==0 -> DATA (bit index 0); bit==1 -> IDLE (false start, no outputs).
  - DATA: at each decision, shift the bit into the shift register, LSB first. After bit index 7 -> STOP.
  - STOP, decision bit==1: byte complete; go IDLE on the same edge.
  - STOP, decision bit==0: frame_err pulse; byte discarded; -> BREAK.
  - BREAK: wait for synchronised rxd==1, then -> IDLE.
- Holding register:
  - On byte complete with data_valid==0, or with data_valid&&data_ready in the same cycle: data_out<=byte, data_valid<=1 on the next edge.
  - On byte complete while data_valid&&!data_ready: overrun pulse; the new byte is dropped; data_out is unchanged.
  - Handshake data_valid&&data_ready with no completion that cycle: data_valid<=0.
  - data_out holds its last value after it is consumed.
- Latency: data_valid rises 1 clk after the STOP decision tick edge.
- Line edge in IDLE during the same cycle as the previous byte completes is not possible; IDLE is entered on that edge, and detection starts the following cycle.
- Reset mid-frame: immediate abort to reset state; the partial byte is lost and there are no pulses.

Decomposition:
- Shared package:
  - baud select encodings BAUD_115200..BAUD_9600
  - multiplier constants 1/3/6/12
  - OVERSAMPLE=16 and sample tick indices 7/8/9
  - FSM state enum IDLE/START/DATA/STOP/BREAK
- One sub-module, uart_rx_tick_gen: prescaler, multiplier counter, sel latch and restart control, output tick.
- Synchroniser, FSM, shift register and holding register stay inline.

Test Plan:
- Settings for 1-5: DIV_BASE=4, bit period 64 clks at sel=00.
1. Assert reset mid-run with rxd=0 -> all outputs 0 and busy=0 during reset. After release with rxd=1, no data_valid for 2000 clks.
2. sel=00, data_ready=1, send 0xA5 at 64 clks/bit -> one data_valid cycle with data_out=0xA5; frame_err=0, overrun=0.
3. sel=11, send 0x3C at 768 clks/bit; toggle sel mid-frame -> data_out=0x3C received correctly; busy high for the whole frame.
4. rxd low for 20 clks then high (sel=00) -> false start; no data_valid; busy returns to 0 within 40 clks. Also: a 1-clk glitch at the bit-7 sample of 0x00 -> majority vote still yields data_out=0x00.
5. Send 0x55 with stop bit held 0 for 3 bit times -> frame_err pulse once; no data_valid; the next frame 0x81 sent after rxd returns high is received correctly.
6. data_ready=0, send 0x11 then 0x22 -> data_out=0x11 held with data_valid=1; overrun pulses once at the end of the second frame. Raise data_ready the same cycle the third byte 0x33 completes -> data_out=0x33, no overrun.

Source files
------------

// File: rtl/uart_rx_brg_pkg.sv
// uart_rx_brg_pkg
// Shared definitions for the 8N1 UART receiver: baud select encodings,
// per-rate tick multipliers, oversampling constants, the receiver FSM
// state type, and a helper that maps a baud select onto its multiplier.
// No ports (package).
package uart_rx_brg_pkg;

    // Baud select encodings, identical to the transmit-side generator
    localparam logic [1:0] BAUD_115200 = 2'b00;
    localparam logic [1:0] BAUD_38400  = 2'b01;
    localparam logic [1:0] BAUD_19200  = 2'b10;
    localparam logic [1:0] BAUD_9600   = 2'b11;

    // Number of base-divider periods per 16x tick for each rate
    localparam logic [3:0] MULT_115200 = 4'd1;
    localparam logic [3:0] MULT_38400  = 4'd3;
    localparam logic [3:0] MULT_19200  = 4'd6;
    localparam logic [3:0] MULT_9600   = 4'd12;

    // Oversampling: 16 ticks per bit, majority vote over ticks 7/8/9
    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] SAMPLE_FIRST = TICK_W'(7);
    localparam logic [TICK_W-1:0] SAMPLE_MID   = TICK_W'(8);
    localparam logic [TICK_W-1:0] SAMPLE_LAST  = TICK_W'(9);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic [3:0] baudMult(input logic [1:0] sel);
        logic [3:0] m;
        case (sel)
            BAUD_115200: m = MULT_115200;
            BAUD_38400:  m = MULT_38400;
            BAUD_19200:  m = MULT_19200;
            default:     m = MULT_9600;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// uart_rx_tick_gen
// Builds the 16x oversample tick for the receiver. A prescaler counts
// 0..DIV_BASE-1; each prescaler wrap advances a multiplier counter that
// counts 0..M-1, and the multiplier wrap is the tick. M is latched from
// sel_i when a frame start is detected so rate changes mid-frame are
// ignored.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   sel_i    baud select, sampled only on start_i
//   start_i  frame start detected: latch M and restart both counters
//   run_i    counters advance while high, held at 0 while low
//   tick_o   one-cycle 16x oversample tick
module uart_rx_tick_gen
    import uart_rx_brg_pkg::*;
#(
    parameter int DIV_BASE = 68
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel_i,
    input  logic       start_i,
    input  logic       run_i,
    output logic       tick_o
);

    localparam int PRE_W = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_BASE - 1);

    logic [PRE_W-1:0] preCnt_q, preCnt_d;
    logic [3:0]       mulCnt_q, mulCnt_d;
    logic [3:0]       mult_q, mult_d;
    logic             preWrap;
    logic             mulWrap;

    assign preWrap = (preCnt_q == PRE_LAST);
    assign mulWrap = (mulCnt_q == (mult_q - 4'd1));
    assign tick_o  = run_i && preWrap && mulWrap;

    // Next-state for the two cascaded counters. A start restarts the
    // count from zero so the first tick lands one full tick period after
    // the start edge was seen.
    always_comb begin
        preCnt_d = preCnt_q;
        mulCnt_d = mulCnt_q;
        mult_d   = mult_q;
        if (start_i) begin
            mult_d   = baudMult(sel_i);
            preCnt_d = '0;
            mulCnt_d = '0;
        end else if (!run_i) begin
            preCnt_d = '0;
            mulCnt_d = '0;
        end else if (preWrap) begin
            preCnt_d = '0;
            mulCnt_d = mulWrap ? 4'd0 : (mulCnt_q + 4'd1);
        end else begin
            preCnt_d = preCnt_q + PRE_W'(1);
        end
    end

    // Counter and latched multiplier registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preCnt_q <= '0;
            mulCnt_q <= '0;
            mult_q   <= MULT_115200;
        end else begin
            preCnt_q <= preCnt_d;
            mulCnt_q <= mulCnt_d;
            mult_q   <= mult_d;
        end
    end

endmodule

// File: rtl/uart_rx_brg.sv
// uart_rx_brg
// 8N1 UART receiver. Synchronises the serial line, majority-votes each
// bit from three 16x samples, assembles bytes LSB-first and hands them
// to the consumer through a single-entry valid/ready holding register.
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   sel         baud select (00=115200, 01=38400, 10=19200, 11=9600)
//   rxd         serial line, idle high, asynchronous to clk
//   data_out    received byte, valid while data_valid is high
//   data_valid  holding register full
//   data_ready  consumer takes the byte when data_valid && data_ready
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   overrun     one-cycle pulse when a byte completes into a full register
//   busy        receiver is anywhere other than IDLE
module uart_rx_brg
    import uart_rx_brg_pkg::*;
#(
    parameter int DIV_BASE    = 68,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    rx_state_e              state_q;
    logic [TICK_W-1:0]      tickIdx_q;
    logic [1:0]             early_q;
    logic [2:0]             bitIdx_q;
    logic [7:0]             shift_q;
    logic [7:0]             dataOut_q;
    logic                   dataValid_q;
    logic                   frameErr_q;
    logic                   overrun_q;

    logic rxdSync;
    logic startDet;
    logic tick;
    logic decide;
    logic bitVal;

    assign rxdSync  = sync_q[SYNC_STAGES-1];
    assign startDet = (state_q == IDLE) && !rxdSync;
    assign decide   = tick && (tickIdx_q == SAMPLE_LAST);

    // Majority of the samples taken at ticks 7 and 8 plus the live
    // sample at tick 9, which is also the decision tick.
    assign bitVal = (early_q[0] & early_q[1]) |
                    (early_q[0] & rxdSync)    |
                    (early_q[1] & rxdSync);

    uart_rx_tick_gen #(
        .DIV_BASE (DIV_BASE)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .sel_i   (sel),
        .start_i (startDet),
        .run_i   (state_q != IDLE),
        .tick_o  (tick)
    );

    // Line synchroniser; resets to the idle-high level so a reset never
    // looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    // Receive FSM, bit sampling, shift register and holding register.
    // The handshake clear is written first so a completion in the same
    // cycle overrides it and reloads the register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tickIdx_q   <= '0;
            early_q     <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
            if (dataValid_q && data_ready) begin
                dataValid_q <= 1'b0;
            end
            if (tick) begin
                tickIdx_q <= tickIdx_q + TICK_W'(1);
                if (tickIdx_q == SAMPLE_FIRST) early_q[0] <= rxdSync;
                if (tickIdx_q == SAMPLE_MID)   early_q[1] <= rxdSync;
            end
            case (state_q)
                IDLE: begin
                    tickIdx_q <= '0;
                    if (!rxdSync) state_q <= START;
                end
                START: begin
                    if (decide) begin
                        if (!bitVal) begin
                            state_q  <= DATA;
                            bitIdx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_q  <= {bitVal, shift_q[7:1]};
                        bitIdx_q <= bitIdx_q + 3'd1;
                        if (bitIdx_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (bitVal) begin
                            state_q <= IDLE;
                            if (!dataValid_q || data_ready) begin
                                dataOut_q   <= shift_q;
                                dataValid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxdSync) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign frame_err  = frameErr_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_brg.sv
// tb_uart_rx_brg
// Directed plus randomized bench for uart_rx_brg with DIV_BASE=4, so a
// bit lasts 64 clocks at sel=00. Frames are driven one clock per step on
// the falling edge; a transaction-level model of the holding register
// predicts which bytes the consumer sees and how many error pulses occur.
module tb_uart_rx_brg;

    localparam int DIV_BASE = 4;
    localparam int BIT_CLKS = 16 * DIV_BASE;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       rxd;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Observed traffic, collected by the monitor
    int         dvCycles = 0;
    int         feCount  = 0;
    int         ovCount  = 0;
    logic [7:0] gotQ[$];

    // Reference model state
    logic       mValid = 1'b0;
    logic [7:0] mData  = 8'h00;
    int         expFe  = 0;
    int         expOv  = 0;
    logic [7:0] expQ[$];

    uart_rx_brg #(
        .DIV_BASE    (DIV_BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .rxd        (rxd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Monitor: samples just after the falling edge, after the stimulus
    // for that edge has settled, and records handshakes and pulses.
    always @(negedge clk) begin
        #1;
        if (reset === 1'b0) begin
            if (data_valid) dvCycles++;
            if (data_valid && data_ready) gotQ.push_back(data_out);
            if (frame_err) feCount++;
            if (overrun) ovCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame: start bit and 8 data bits LSB-first for bitClks
    // each, then the stop level for stopClks; optionally invert the line
    // for the single clock with index glitchAt.
    task automatic applyStimulus(input logic [7:0] b, input int bitClks,
                                 input logic stopVal, input int stopClks,
                                 input int glitchAt);
        logic [8:0] frame;
        frame = {b, 1'b0};
        for (int n = 0; n < 9 * bitClks + stopClks; n++) begin
            if (n < 9 * bitClks) rxd = frame[n / bitClks];
            else                 rxd = stopVal;
            if (n == glitchAt) rxd = ~rxd;
            @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    // A frame finishes: bad stop -> frame error; full register with no
    // consumer -> overrun; otherwise the old byte (if any) is taken by the
    // consumer in the same cycle and the new byte is loaded.
    task automatic modelComplete(input logic [7:0] b, input logic stopOk,
                                 input logic readyNow);
        if (!stopOk) begin
            expFe++;
        end else if (mValid && !readyNow) begin
            expOv++;
        end else begin
            if (mValid) expQ.push_back(mData);
            mData  = b;
            mValid = 1'b1;
        end
    endtask

    // Consumer is ready afterwards: any held byte gets taken
    task automatic modelDrain();
        if (mValid) begin
            expQ.push_back(mData);
            mValid = 1'b0;
        end
    endtask

    task automatic checkTraffic(input string tag);
        checkOutput({tag, " byte count"}, gotQ.size(), expQ.size());
        while (expQ.size() > 0 && gotQ.size() > 0) begin
            checkOutput({tag, " byte"}, gotQ.pop_front(), expQ.pop_front());
        end
        gotQ.delete();
        expQ.delete();
        checkOutput({tag, " frame_err pulses"}, feCount, expFe);
        checkOutput({tag, " overrun pulses"}, ovCount, expOv);
    endtask

    initial begin
        int         busyLow;
        int         dvBase;
        logic [7:0] rb;
        logic [1:0] rs;

        reset      = 1'b1;
        rxd        = 1'b1;
        sel        = 2'b00;
        data_ready = 1'b1;
        waitClocks(3);

        // Reset state
        checkOutput("reset data_out", data_out, 8'h00);
        checkOutput("reset data_valid", data_valid, 1'b0);
        checkOutput("reset frame_err", frame_err, 1'b0);
        checkOutput("reset overrun", overrun, 1'b0);
        checkOutput("reset busy", busy, 1'b0);

        // Reset asserted in the middle of a frame with the line low
        reset = 1'b0;
        waitClocks(10);
        rxd = 1'b0;
        waitClocks(300);
        checkOutput("mid-frame busy", busy, 1'b1);
        reset = 1'b1;
        waitClocks(3);
        checkOutput("abort outputs", {data_out, data_valid, frame_err, overrun, busy}, 12'h000);
        rxd = 1'b1;
        waitClocks(2);
        reset = 1'b0;
        waitClocks(2000);
        checkOutput("post-reset data_valid cycles", dvCycles, 0);
        checkOutput("post-reset busy", busy, 1'b0);
        $display("[TB] reset checks done");

        // Basic byte at 115200
        dvBase = dvCycles;
        applyStimulus(8'hA5, BIT_CLKS, 1'b1, BIT_CLKS, -1);
        modelComplete(8'hA5, 1'b1, 1'b1);
        modelDrain();
        waitClocks(20);
        checkOutput("A5 data_valid cycles", dvCycles - dvBase, 1);
        checkOutput("A5 data_out", data_out, mData);
        checkTraffic("A5");

        // 9600 with sel toggled mid-frame; busy held for the whole frame
        sel     = 2'b11;
        busyLow = 0;
        waitClocks(5);
        fork
            applyStimulus(8'h3C, 12 * BIT_CLKS, 1'b1, 12 * BIT_CLKS, -1);
            begin
                waitClocks(2000);
                sel = 2'b00;
                waitClocks(2000);
                sel = 2'b01;
            end
            begin
                waitClocks(5);
                for (int n = 5; n < 7380; n++) begin
                    if (busy !== 1'b1) busyLow++;
                    @(negedge clk);
                end
            end
        join
        modelComplete(8'h3C, 1'b1, 1'b1);
        modelDrain();
        sel = 2'b00;
        waitClocks(20);
        checkOutput("3C busy low cycles", busyLow, 0);
        checkOutput("3C busy after frame", busy, 1'b0);
        checkTraffic("3C");

        // False start: short low pulse
        rxd = 1'b0;
        waitClocks(20);
        rxd = 1'b1;
        waitClocks(40);
        checkOutput("false start busy", busy, 1'b0);
        checkTraffic("false start");

        // One-clock glitch on the middle sample of data bit 7
        waitClocks(10);
        applyStimulus(8'h00, BIT_CLKS, 1'b1, BIT_CLKS, 8 * BIT_CLKS + 36);
        modelComplete(8'h00, 1'b1, 1'b1);
        modelDrain();
        waitClocks(20);
        checkTraffic("glitch");

        // Stop bit held low for three bit times, then recovery
        applyStimulus(8'h55, BIT_CLKS, 1'b0, 3 * BIT_CLKS, -1);
        modelComplete(8'h55, 1'b0, 1'b1);
        waitClocks(20);
        checkOutput("break exit busy", busy, 1'b0);
        applyStimulus(8'h81, BIT_CLKS, 1'b1, BIT_CLKS, -1);
        modelComplete(8'h81, 1'b1, 1'b1);
        modelDrain();
        waitClocks(20);
        checkTraffic("break recovery");

        // Holding register with a stalled consumer
        data_ready = 1'b0;
        applyStimulus(8'h11, BIT_CLKS, 1'b1, BIT_CLKS, -1);
        modelComplete(8'h11, 1'b1, 1'b0);
        waitClocks(20);
        checkOutput("held 11 data_valid", data_valid, mValid);
        checkOutput("held 11 data_out", data_out, mData);
        applyStimulus(8'h22, BIT_CLKS, 1'b1, BIT_CLKS, -1);
        modelComplete(8'h22, 1'b1, 1'b0);
        waitClocks(20);
        checkOutput("overrun data_valid", data_valid, mValid);
        checkOutput("overrun data_out", data_out, mData);
        checkTraffic("overrun");

        // Consumer becomes ready in the very cycle the third byte completes
        fork
            applyStimulus(8'h33, BIT_CLKS, 1'b1, BIT_CLKS, -1);
            begin
                waitClocks(618);
                data_ready = 1'b1;
            end
        join
        modelComplete(8'h33, 1'b1, 1'b1);
        modelDrain();
        waitClocks(20);
        checkOutput("simultaneous data_out", data_out, mData);
        checkOutput("simultaneous data_valid", data_valid, mValid);
        checkTraffic("simultaneous");

        // Random bytes at random rates with random idle gaps
        for (int i = 0; i < 6; i++) begin
            rb  = 8'($urandom_range(0, 255));
            rs  = 2'($urandom_range(0, 1));
            sel = rs;
            waitClocks(5 + int'($urandom_range(0, 100)));
            applyStimulus(rb, BIT_CLKS * ((rs == 2'b01) ? 3 : 1), 1'b1,
                          BIT_CLKS * ((rs == 2'b01) ? 3 : 1), -1);
            modelComplete(rb, 1'b1, 1'b1);
            modelDrain();
        end
        waitClocks(20);
        checkOutput("random data_out", data_out, mData);
        checkTraffic("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
